// File: rtl/rgmii_nibble_tx.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_nibble_tx
// Brief    : AXI-stream to 10/100 RGMII nibble framer (preamble, pad, FCS, IFG)
// Revision : 1.0  initial release
// ============================================================================
module rgmii_nibble_tx #(
    parameter int MIN_FRAME_LEN  = 64,
    parameter int IFG_BYTES      = 12,
    parameter int ENABLE_PADDING = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_enable,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [3:0] phy_txd,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic       start_packet,
    output logic       error_underflow
);

    localparam logic [15:0] c_pad_target = 16'(MIN_FRAME_LEN - 4);
    localparam logic [15:0] c_ifg_last   = 16'(2 * IFG_BYTES);
    localparam logic [31:0] c_poly       = 32'hEDB88320;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_PAD      = 3'd3,
        S_FCS      = 3'd4,
        S_ERR      = 3'd5,
        S_IFG      = 3'd6,
        S_DROP     = 3'd7
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_byte_cnt;
    logic [31:0] r_crc;
    logic        r_hi;
    logic [3:0]  r_hold;
    logic        r_last;
    logic        r_bad;
    logic [3:0]  r_txd;
    logic        r_tx_en;
    logic        r_tx_er;
    logic        r_start;
    logic        r_underflow;
    logic [31:0] w_fcs;
    logic [3:0]  w_fcs_nib;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ c_poly) : (c >> 1);
        end
        return c;
    endfunction

    assign w_fcs     = ~r_crc;
    assign w_fcs_nib = w_fcs[{r_cnt[2:0], 2'b00} +: 4];

    assign s_axis_tready = ((r_state == S_PAYLOAD) && !r_hi && clk_enable) || (r_state == S_DROP);

    assign phy_txd         = r_txd;
    assign phy_tx_en       = r_tx_en;
    assign phy_tx_er       = r_tx_er;
    assign start_packet    = r_start;
    assign error_underflow = r_underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'h0;
            r_byte_cnt  <= 16'h0;
            r_crc       <= 32'h0;
            r_hi        <= 1'b0;
            r_hold      <= 4'h0;
            r_last      <= 1'b0;
            r_bad       <= 1'b0;
            r_txd       <= 4'h0;
            r_tx_en     <= 1'b0;
            r_tx_er     <= 1'b0;
            r_start     <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_underflow <= 1'b0;
            if (r_state == S_DROP) begin
                // Draining runs at full clk rate; only the idle outputs follow the strobe.
                if (s_axis_tvalid && s_axis_tlast) begin
                    r_state <= S_IFG;
                    r_cnt   <= 16'h0;
                end
                if (clk_enable) begin
                    r_txd   <= 4'h0;
                    r_tx_en <= 1'b0;
                    r_tx_er <= 1'b0;
                end
            end else if (clk_enable) begin
                case (r_state)
                    S_IDLE: begin
                        r_txd   <= 4'h0;
                        r_tx_en <= 1'b0;
                        r_tx_er <= 1'b0;
                        if (s_axis_tvalid) begin
                            r_txd      <= 4'h5;
                            r_tx_en    <= 1'b1;
                            r_start    <= 1'b1;
                            r_state    <= S_PREAMBLE;
                            r_cnt      <= 16'd1;
                            r_crc      <= 32'hFFFF_FFFF;
                            r_byte_cnt <= 16'h0;
                            r_hi       <= 1'b0;
                            r_last     <= 1'b0;
                            r_bad      <= 1'b0;
                        end
                    end
                    S_PREAMBLE: begin
                        r_tx_en <= 1'b1;
                        r_tx_er <= 1'b0;
                        if (r_cnt == 16'd15) begin
                            r_txd   <= 4'hD;
                            r_state <= S_PAYLOAD;
                            r_hi    <= 1'b0;
                        end else begin
                            r_txd <= 4'h5;
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_PAYLOAD: begin
                        r_tx_en <= 1'b1;
                        if (!r_hi) begin
                            if (s_axis_tvalid) begin
                                r_txd  <= s_axis_tdata[3:0];
                                r_tx_er <= 1'b0;
                                r_hold <= s_axis_tdata[7:4];
                                r_crc  <= crc_next(r_crc, s_axis_tdata);
                                if (r_byte_cnt != 16'hFFFF) begin
                                    r_byte_cnt <= r_byte_cnt + 16'd1;
                                end
                                r_last <= s_axis_tlast;
                                r_bad  <= s_axis_tlast && s_axis_tuser;
                                r_hi   <= 1'b1;
                            end else begin
                                // First of the two error nibbles goes out on the detecting slot.
                                r_txd       <= 4'h0;
                                r_tx_er     <= 1'b1;
                                r_underflow <= 1'b1;
                                r_state     <= S_ERR;
                            end
                        end else begin
                            r_txd   <= r_hold;
                            r_tx_er <= 1'b0;
                            r_hi    <= 1'b0;
                            if (r_last) begin
                                r_cnt   <= 16'h0;
                                r_state <= ((ENABLE_PADDING != 0) && (r_byte_cnt < c_pad_target))
                                           ? S_PAD : S_FCS;
                            end
                        end
                    end
                    S_PAD: begin
                        r_txd   <= 4'h0;
                        r_tx_en <= 1'b1;
                        r_tx_er <= 1'b0;
                        if (!r_hi) begin
                            r_crc <= crc_next(r_crc, 8'h00);
                            if (r_byte_cnt != 16'hFFFF) begin
                                r_byte_cnt <= r_byte_cnt + 16'd1;
                            end
                            r_hi <= 1'b1;
                        end else begin
                            r_hi <= 1'b0;
                            if (r_byte_cnt >= c_pad_target) begin
                                r_cnt   <= 16'h0;
                                r_state <= S_FCS;
                            end
                        end
                    end
                    S_FCS: begin
                        r_txd   <= w_fcs_nib;
                        r_tx_en <= 1'b1;
                        r_tx_er <= r_bad;
                        if (r_cnt == 16'd7) begin
                            r_cnt   <= 16'h0;
                            r_state <= S_IFG;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_ERR: begin
                        r_txd   <= 4'h0;
                        r_tx_en <= 1'b1;
                        r_tx_er <= 1'b1;
                        r_state <= S_DROP;
                    end
                    S_IFG: begin
                        // 2*IFG_BYTES gap nibbles plus the terminal cycle that hands back to IDLE.
                        r_txd   <= 4'h0;
                        r_tx_en <= 1'b0;
                        r_tx_er <= 1'b0;
                        if (r_cnt == c_ifg_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgmii_nibble_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgmii_nibble_tx
// Brief    : Directed self-checking bench for rgmii_nibble_tx (padded and unpadded)
// Revision : 1.0  initial release
// ============================================================================
module tb_rgmii_nibble_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_enable;
    logic       gate = 1'b0;
    int         cyc  = 0;
    logic       sel;
    logic       tv;
    logic [7:0] tdata;
    logic       tlast;
    logic       tuser;

    logic       tvalid_a, tvalid_b, tready_a, tready_b, tready_sel;
    logic [3:0] txd_a, txd_b;
    logic       en_a, en_b, er_a, er_b, start_a, start_b, uf_a, uf_b;
    logic [5:0] mon;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc        = cyc + 1;
        clk_enable = gate ? ((cyc % 10) == 0) : 1'b1;
    end

    assign tvalid_a   = !sel && tv;
    assign tvalid_b   = sel && tv;
    assign tready_sel = sel ? tready_b : tready_a;
    assign mon        = sel ? {er_b, en_b, txd_b} : {er_a, en_a, txd_a};

    rgmii_nibble_tx #(.MIN_FRAME_LEN(64), .IFG_BYTES(12), .ENABLE_PADDING(0)) u_dut_nopad (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_a), .s_axis_tready(tready_a),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .phy_txd(txd_a), .phy_tx_en(en_a), .phy_tx_er(er_a),
        .start_packet(start_a), .error_underflow(uf_a)
    );

    rgmii_nibble_tx u_dut_pad (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_b), .s_axis_tready(tready_b),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .phy_txd(txd_b), .phy_tx_en(en_b), .phy_tx_er(er_b),
        .start_packet(start_b), .error_underflow(uf_b)
    );

    // One captured record {er,en,txd} per nibble loaded on an enabled edge.
    logic       en_d;
    logic [5:0] cap[$];
    int         idle_run = 0;
    int         n_start  = 0;
    int         n_uf     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_d <= 1'b0;
        else        en_d <= clk_enable;
    end

    always @(negedge clk) begin
        if (rst_n && en_d) begin
            cap.push_back(mon);
            if (mon[4]) idle_run = 0;
            else        idle_run = idle_run + 1;
        end
        if (rst_n && (sel ? start_b : start_a)) n_start = n_start + 1;
        if (rst_n && (sel ? uf_b : uf_a))       n_uf = n_uf + 1;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    int         off_en   = 0;
    logic [7:0] fb[0:255];
    logic [5:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic build_exp(input int n, input bit pad, input bit user);
        logic [31:0] crc;
        logic [7:0]  b;
        int          tot;
        exp_q.delete();
        for (int i = 0; i < 15; i++) exp_q.push_back(6'h15);
        exp_q.push_back(6'h1D);
        crc = 32'hFFFF_FFFF;
        tot = (pad && n < 60) ? 60 : n;
        for (int i = 0; i < tot; i++) begin
            b   = (i < n) ? fb[i] : 8'h00;
            crc = crc_upd(crc, b);
            exp_q.push_back({2'b01, b[3:0]});
            exp_q.push_back({2'b01, b[7:4]});
        end
        crc = ~crc;
        for (int k = 0; k < 8; k++) exp_q.push_back({user, 1'b1, crc[4*k +: 4]});
    endtask

    function automatic int next_frame(input int from, output int len);
        int s = from;
        while (s < cap.size() && !cap[s][4]) s++;
        len = 0;
        while (s + len < cap.size() && cap[s+len][4]) len++;
        return s;
    endfunction

    function automatic int count_er(input int s, input int len);
        int c = 0;
        for (int i = 0; i < len; i++) if (cap[s+i][5]) c++;
        return c;
    endfunction

    task automatic check_frame(input string tag, input int s, input int len);
        int bad = -1;
        check({tag, " length"}, len, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= len || cap[s+i] !== exp_q[i])) bad = i;
        check({tag, " first bad nibble"}, bad, -1);
    endtask

    task automatic send(input int n, input bit user, input int stall_at, input int stall,
                        input bit keep, output int acc_after);
        int i       = 0;
        int guard   = 0;
        bit stalled = 1'b0;
        acc_after = 0;
        while (i < n && guard < 6000) begin
            @(negedge clk);
            if (i == stall_at && !stalled) begin
                tv = 1'b0;
                repeat (stall) @(negedge clk);
                stalled = 1'b1;
            end
            tv    = 1'b1;
            tdata = fb[i];
            tlast = (i == n - 1);
            tuser = user && (i == n - 1);
            #4;
            if (tready_sel && !clk_enable) off_en++;
            if (tready_sel) begin
                i++;
                if (stalled) acc_after++;
            end
            guard++;
        end
        check("send bytes accepted", i, n);
        if (!keep) begin
            @(negedge clk);
            tv = 1'b0; tlast = 1'b0; tuser = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (idle_run < 30 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check({tag, " idle reached"}, idle_run >= 30, 1);
    endtask

    initial begin
        int s, len, s2, len2, acc, base, nst, nuf, off0, gap;
        logic [31:0] fcs;
        rst_n = 1'b0; sel = 1'b1; tv = 1'b0; tdata = 8'h00; tlast = 1'b0; tuser = 1'b0;
        repeat (3) @(negedge clk);
        check("reset txd",       txd_b, 0);
        check("reset tx_en",     en_b, 0);
        check("reset tx_er",     er_b, 0);
        check("reset tready",    tready_b, 0);
        check("reset start",     start_b, 0);
        check("reset underflow", uf_b, 0);
        check("reset tx_en nopad", en_a, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Unpadded "123456789", continuous enable
        sel = 1'b0;
        for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
        base = cap.size(); nst = n_start;
        send(9, 1'b0, -1, 0, 1'b0, acc);
        wait_idle("t1");
        build_exp(9, 1'b0, 1'b0);
        s = next_frame(base, len);
        check_frame("t1", s, len);
        check("t1 er count", count_er(s, len), 0);
        fcs = 32'h0;
        for (int k = 0; k < 8; k++) if (s + 34 + k < cap.size()) fcs[4*k +: 4] = cap[s+34+k][3:0];
        check("t1 fcs", fcs, 32'hCBF43926);
        check("t1 start pulses", n_start - nst, 1);

        // Same frame, enable every 10th cycle
        gate = 1'b1;
        repeat (20) @(negedge clk);
        base = cap.size(); off0 = off_en;
        send(9, 1'b0, -1, 0, 1'b0, acc);
        wait_idle("t4");
        s = next_frame(base, len);
        check_frame("t4", s, len);
        check("t4 tready off-enable", off_en - off0, 0);
        gate = 1'b0;
        repeat (5) @(negedge clk);

        // Padded single zero byte
        sel = 1'b1;
        repeat (5) @(negedge clk);
        fb[0] = 8'h00;
        base = cap.size();
        send(1, 1'b0, -1, 0, 1'b0, acc);
        wait_idle("t2");
        build_exp(1, 1'b1, 1'b0);
        s = next_frame(base, len);
        check_frame("t2", s, len);

        // Two back-to-back 64-byte frames, tvalid never drops
        for (int i = 0; i < 64; i++) fb[i] = 8'(i * 3 + 1);
        base = cap.size(); nst = n_start; nuf = n_uf;
        send(64, 1'b0, -1, 0, 1'b1, acc);
        send(64, 1'b0, -1, 0, 1'b0, acc);
        wait_idle("t3");
        build_exp(64, 1'b1, 1'b0);
        s  = next_frame(base, len);
        s2 = next_frame(s + len, len2);
        check_frame("t3 frame1", s, len);
        check_frame("t3 frame2", s2, len2);
        check("t3 gap", s2 - (s + len), 25);
        check("t3 start pulses", n_start - nst, 2);
        check("t3 underflows", n_uf - nuf, 0);

        // Underflow after byte 3 of a 20-byte frame, then a clean frame
        for (int i = 0; i < 20; i++) fb[i] = 8'h40 + 8'(i);
        base = cap.size(); nuf = n_uf;
        send(20, 1'b0, 4, 4, 1'b1, acc);
        check("t5 drained bytes", acc, 16);
        send(20, 1'b0, -1, 0, 1'b0, acc);
        wait_idle("t5");
        build_exp(20, 1'b1, 1'b0);
        while (exp_q.size() > 24) void'(exp_q.pop_back());
        exp_q.push_back(6'h30);
        exp_q.push_back(6'h30);
        s  = next_frame(base, len);
        check_frame("t5 aborted", s, len);
        check("t5 err nibbles", count_er(s, len), 2);
        check("t5 underflow pulses", n_uf - nuf, 1);
        s2 = next_frame(s + len, len2);
        // 17 DROP nibbles while draining, then 25 from IFG/IDLE
        check("t5 gap", s2 - (s + len), 42);
        build_exp(20, 1'b1, 1'b0);
        check_frame("t5 next", s2, len2);

        // Bad-frame flag
        fb[0] = 8'hDE; fb[1] = 8'hAD;
        base = cap.size();
        send(2, 1'b1, -1, 0, 1'b0, acc);
        wait_idle("t6");
        build_exp(2, 1'b1, 1'b1);
        s = next_frame(base, len);
        check_frame("t6", s, len);
        check("t6 er count", count_er(s, len), 8);

        // Reset in the middle of the payload
        tv = 1'b1; tdata = 8'h11; tlast = 1'b0; tuser = 1'b0;
        repeat (30) @(negedge clk);
        check("t7 tx_en before reset", en_b, 1);
        rst_n = 1'b0;
        #1;
        check("t7 txd",       txd_b, 0);
        check("t7 tx_en",     en_b, 0);
        check("t7 tx_er",     er_b, 0);
        check("t7 tready",    tready_b, 0);
        check("t7 start",     start_b, 0);
        check("t7 underflow", uf_b, 0);
        tv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = cap.size();
        repeat (40) @(negedge clk);
        s = next_frame(base, len);
        check("t7 no output after reset", len, 0);
        fb[0] = 8'h77;
        base = cap.size(); nst = n_start;
        send(1, 1'b0, -1, 0, 1'b0, acc);
        wait_idle("t7");
        build_exp(1, 1'b1, 1'b0);
        s = next_frame(base, len);
        check_frame("t7 next", s, len);
        check("t7 start pulses", n_start - nst, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgmii_nibble_tx.md
# rgmii_nibble_tx

Transmit-side MAC framing stage that sits directly upstream of the RGMII PHY interface. It accepts frame bytes on an AXI-stream slave and emits 10/100-mode nibble data (`phy_txd`, `phy_tx_en`, `phy_tx_er`) for the downstream RGMII output stage, which forms `phy_tx_ctl` and drives `phy_tx_clk`. Per frame it generates:

- the preamble and SFD,
- payload nibbles, low nibble first,
- zero padding up to the minimum frame length,
- the Ethernet FCS,
- the inter-frame gap.

## Interface
Parameters:
- `MIN_FRAME_LEN`, 64: minimum frame bytes including FCS; padding target is `MIN_FRAME_LEN-4` payload bytes.
- `IFG_BYTES`, 12: inter-frame gap in bytes; the gap is `2*IFG_BYTES` enabled cycles.
- `ENABLE_PADDING`, 1: 1 pads short frames with 0x00; 0 sends the payload unpadded.

Ports:
- `clk`  in  1: single clock; all logic is in this domain.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `clk_enable`  in  1: nibble strobe; the FSM and outputs advance only on cycles where it is 1.
- `s_axis_tdata`  in  8: payload byte.
- `s_axis_tvalid`  in  1: byte valid.
- `s_axis_tready`  out  1: byte accepted this cycle when high together with tvalid.
- `s_axis_tlast`  in  1: last payload byte of the frame.
- `s_axis_tuser`  in  1: bad-frame flag, sampled together with tlast.
- `phy_txd`  out  4: nibble to the RGMII output stage.
- `phy_tx_en`  out  1: transmit enable.
- `phy_tx_er`  out  1: transmit error.
- `start_packet`  out  1: one-cycle pulse when the first preamble nibble is loaded.
- `error_underflow`  out  1: one-cycle pulse when an underflow is detected.

## Operation
- FSM states: IDLE, PREAMBLE, PAYLOAD, PAD, FCS, ERR, IFG, DROP.
- Output registers (`phy_txd`, `phy_tx_en`, `phy_tx_er`) load only on `clk_enable` cycles and otherwise hold their values.
- IDLE:
  - Outputs are 0 and `s_axis_tready`=0.
  - On a `clk_enable` cycle with tvalid=1: load nibble 0x5 with tx_en=1, pulse `start_packet`, go to PREAMBLE.
- PREAMBLE:
  - Sends 16 nibbles in total: 15×0x5, then 0xD (SFD 0xD5, low nibble first).
  - Then goes to PAYLOAD.
- PAYLOAD:
  - Each byte takes two enabled cycles: low nibble, then high nibble.
  - `s_axis_tready` = `clk_enable` and (low-nibble slot of PAYLOAD). It is combinational.
  - The accepted byte loads directly: the low nibble goes to `phy_txd`, the high nibble is held.
  - A 16-bit byte counter counts accepted bytes. The CRC is updated per accepted byte.
  - On tlast: if `ENABLE_PADDING`=1 and count < `MIN_FRAME_LEN-4`, go to PAD; otherwise go to FCS.
  - tuser=1 with tlast latches a `bad_frame` flag for FCS.
- Underflow: in a low-nibble slot with tvalid=0:
  - pulse `error_underflow` and go to ERR;
  - ERR drives 2 nibbles of 0x0 with tx_en=1, tx_er=1;
  - then go to DROP.
- DROP:
  - `s_axis_tready`=1 every cycle, regardless of `clk_enable`.
  - Outputs are 0.
  - Stays until a byte with tlast is consumed, then goes to IFG. The IFG count restarts on entry.
- PAD: sends 0x00 bytes, counted and included in the CRC, until count = `MIN_FRAME_LEN-4`.
- FCS:
  - CRC-32 with reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF before the first payload byte; the transmitted value is the bitwise inverse.
  - Sent as 4 bytes, least-significant byte first, each byte low nibble first: 8 nibbles.
  - When `bad_frame` is set, tx_er=1 on all 8 FCS nibbles.
- IFG:
  - Outputs are 0 for `2*IFG_BYTES` enabled cycles, then go to IDLE.
  - tvalid is ignored during IFG.
- The byte counter saturates at 0xFFFF; there is no maximum-length check.

## Timing
- Reset (`rst_n`=0) takes effect immediately, asynchronously, and returns the FSM to IDLE. While `rst_n`=0:
  - `phy_txd`=0, `phy_tx_en`=0, `phy_tx_er`=0;
  - `start_packet`=0, `error_underflow`=0;
  - `s_axis_tready`=0;
  - the CRC and all counters are cleared.
- Reset mid-frame truncates output on the spot; no FCS or IFG is emitted. The next frame starts cleanly from IDLE after reset.
- Outputs are registered: a nibble loaded on an enabled cycle appears on the following clk edge.
- `clk_enable` held at 1 gives one nibble per clk. Any gating pattern must produce identical nibble sequences.
- Latency: tvalid seen in IDLE → first byte accepted on the 17th enabled cycle after it, counting the IDLE cycle as the 1st.
- Frame length on the wire, in nibbles with tx_en=1: 16 + 2·max(N, pad target) + 8. With `ENABLE_PADDING`=0 the max reduces to N.
- Back-to-back frames: tx_en-low gap is exactly `2*IFG_BYTES` enabled cycles, plus one enabled cycle for IDLE detection.

## Test plan
- `ENABLE_PADDING`=0, continuous enable, send the 9 bytes "123456789" (0x31..0x39):
  - tx_en high for 42 nibbles: 15×0x5, 0xD, then 1,3,2,3,…,9,3;
  - FCS bytes 26 39 F4 CB (CRC 0xCBF43926), i.e. nibbles 6,2,9,3,4,F,B,C;
  - tx_er=0 throughout.
- Default parameters, 1-byte frame 0x00:
  - 59 pad bytes;
  - tx_en high for exactly 144 nibbles;
  - the FCS matches the software CRC over 60 zero bytes;
  - followed by 24 idle nibbles.
- Two back-to-back 64-byte frames with tvalid always high:
  - inter-frame gap is exactly 25 enabled cycles;
  - `start_packet` pulses twice;
  - no underflow.
- `clk_enable` asserted every 10th cycle, same frame as test 1:
  - nibble sequence identical to test 1;
  - tready pulses only on enabled cycles.
- tvalid dropped after payload byte 3 of a 20-byte frame:
  - `error_underflow` pulses once;
  - 2 nibbles with tx_en=tx_er=1;
  - the remaining 16 bytes are drained with tready=1;
  - 24 idle nibbles follow;
  - the next frame is sent correctly.
- tlast with tuser=1 → tx_er=1 on exactly the 8 FCS nibbles. Assert `rst_n`=0 mid-PAYLOAD → all outputs 0 the same cycle; the next frame starts from IDLE.
